// File: rtl/sccb_cfg_sequencer.sv
// Purpose : SCCB/I2C write-only sequencer that walks a register table and writes each entry to a sensor.
// Latency : 3 + 9*(1+REG_BYTES+DATA_BYTES) clk2 cycles per register (39 with defaults), START through STOP2.
// Backpressure: none on the bus side; start is ignored while busy, and NACKs abort the current frame.
//
// Ports:
//   clk2      - bit clock, one SDA bit per cycle; all state on posedge, sda sampled on negedge
//   reset     - asynchronous, active-low; releases SDA immediately, no STOP generated
//   start     - begins a sweep when sampled in IDLE or DONE
//   sda       - SDA line from the pad (ACK/NACK sampling)
//   cfg_data  - table data for cfg_index, valid one cycle after cfg_index changes
//   cfg_index - current table index, also used as the register address
//   sda_w     - SDA drive value (1 = release)
//   ctrl_h    - 1 = hold SCL high, 0 = let SCL toggle with clk2
//   busy/done/error/nack_cnt - sweep status
//
// Build option: define I2C_RETRY_EN to retry a NACKed register up to MAX_RETRY
// times before abandoning it; without it a NACKed register is skipped at once.

module sccb_cfg_sequencer #(
    parameter logic [7:0] DEV_ADDR   = 8'hBA,
    parameter int         REG_BYTES  = 1,
    parameter int         DATA_BYTES = 2,
    parameter int         IDX_W      = 8,
    parameter int         START_IDX  = 0,
    parameter int         END_IDX    = 255,
    parameter int         MAX_RETRY  = 3
) (
    input  logic                    clk2,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    sda,
    input  logic [8*DATA_BYTES-1:0] cfg_data,
    output logic [IDX_W-1:0]        cfg_index,
    output logic                    sda_w,
    output logic                    ctrl_h,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [7:0]              nack_cnt
);

    localparam int                NBYTES    = 1 + REG_BYTES + DATA_BYTES;
    localparam int                FRAME_W   = 8 * NBYTES;
    localparam int                RA_W      = 8 * REG_BYTES;
    localparam logic [2:0]        LAST_BYTE = 3'(NBYTES - 1);
    localparam logic [IDX_W-1:0]  FIRST_IX  = IDX_W'(START_IDX);
    localparam logic [IDX_W-1:0]  LAST_IX   = IDX_W'(END_IDX);

    // Reject parameter sets the byte counter and sweep logic cannot handle.
    if (END_IDX < START_IDX || REG_BYTES < 1 || REG_BYTES > 2 ||
        DATA_BYTES < 1 || DATA_BYTES > 4 || MAX_RETRY < 0 || MAX_RETRY > 255) begin : g_bad_params
        $error("sccb_cfg_sequencer: unsupported parameter combination");
    end

`ifdef I2C_RETRY_EN
    localparam int          RC_W        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RC_W-1:0] RETRY_LIMIT = RC_W'(MAX_RETRY);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BITS,
        S_ACK,
        S_STOP1,
        S_STOP2,
        S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [2:0]              bitcnt, bitcnt_nxt;
    logic [2:0]              byte_cnt, byte_nxt;
    logic [8*DATA_BYTES-1:0] shadow, shadow_nxt;
    logic [IDX_W-1:0]        index_nxt;
    logic                    error_nxt;
    logic [7:0]              nack_nxt;
    logic                    finish_r, finish_nxt;
    logic                    close_reg;
    logic                    sda_r;
`ifdef I2C_RETRY_EN
    logic [RC_W-1:0]         retry_cnt, retry_nxt;
`endif

    logic [RA_W-1:0]         reg_addr;
    logic [FRAME_W-1:0]      frame;
    logic [FRAME_W-1:0]      frame_sh;
    logic [7:0]              cur_byte;

    // Slave ACK/NACK is sampled mid-cycle so it is settled well before the
    // posedge that evaluates it.
    always_ff @(negedge clk2 or negedge reset) begin
        if (!reset) begin
            sda_r <= 1'b1;
        end else begin
            sda_r <= sda;
        end
    end

    // Whole frame as one vector; the byte on the wire is the top byte after
    // shifting out the bytes already sent. The register address tracks the
    // live cfg_index, which only moves once the frame's last ACK is decided.
    always_comb begin
        reg_addr = RA_W'(cfg_index);
        frame    = {DEV_ADDR, reg_addr, shadow};
        frame_sh = frame << {byte_cnt, 3'b000};
        cur_byte = frame_sh[FRAME_W-1 -: 8];
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bitcnt    <= 3'd7;
            byte_cnt  <= 3'd0;
            shadow    <= '0;
            cfg_index <= FIRST_IX;
            error     <= 1'b0;
            nack_cnt  <= 8'd0;
            finish_r  <= 1'b0;
`ifdef I2C_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            state     <= state_nxt;
            bitcnt    <= bitcnt_nxt;
            byte_cnt  <= byte_nxt;
            shadow    <= shadow_nxt;
            cfg_index <= index_nxt;
            error     <= error_nxt;
            nack_cnt  <= nack_nxt;
            finish_r  <= finish_nxt;
`ifdef I2C_RETRY_EN
            retry_cnt <= retry_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        byte_nxt   = byte_cnt;
        shadow_nxt = shadow;
        index_nxt  = cfg_index;
        error_nxt  = error;
        nack_nxt   = nack_cnt;
        finish_nxt = finish_r;
        close_reg  = 1'b0;
`ifdef I2C_RETRY_EN
        retry_nxt  = retry_cnt;
`endif
        sda_w      = 1'b1;
        ctrl_h     = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                busy = 1'b0;
                done = (state == S_DONE);
                // On restart from DONE the shadow takes whatever the table
                // presents alongside start; cfg_index only returns to
                // START_IDX on this same edge.
                if (start) begin
                    state_nxt  = S_START;
                    error_nxt  = 1'b0;
                    nack_nxt   = 8'd0;
                    shadow_nxt = cfg_data;
                    index_nxt  = FIRST_IX;
                    byte_nxt   = 3'd0;
                    bitcnt_nxt = 3'd7;
                    finish_nxt = 1'b0;
`ifdef I2C_RETRY_EN
                    retry_nxt  = '0;
`endif
                end
            end

            S_START: begin
                sda_w     = 1'b0;
                state_nxt = S_BITS;
            end

            S_BITS: begin
                ctrl_h = 1'b0;
                sda_w  = cur_byte[bitcnt];
                if (bitcnt == 3'd0) begin
                    bitcnt_nxt = 3'd7;
                    state_nxt  = S_ACK;
                end else begin
                    bitcnt_nxt = bitcnt - 3'd1;
                end
            end

            S_ACK: begin
                ctrl_h = 1'b0;
                sda_w  = 1'b1;
                if (!sda_r) begin
                    if (byte_cnt != LAST_BYTE) begin
                        byte_nxt  = byte_cnt + 3'd1;
                        state_nxt = S_BITS;
                    end else begin
                        state_nxt = S_STOP1;
                        close_reg = 1'b1;
                    end
                end else begin
                    state_nxt = S_STOP1;
                    if (nack_cnt != 8'hFF) begin
                        nack_nxt = nack_cnt + 8'd1;
                    end
`ifdef I2C_RETRY_EN
                    // Retry the same index until the limit, then give up on it.
                    if (retry_cnt == RETRY_LIMIT) begin
                        error_nxt = 1'b1;
                        close_reg = 1'b1;
                    end else begin
                        retry_nxt = retry_cnt + 1'b1;
                    end
`else
                    error_nxt = 1'b1;
                    close_reg = 1'b1;
`endif
                end
            end

            S_STOP1: begin
                sda_w     = 1'b0;
                state_nxt = S_STOP2;
            end

            S_STOP2: begin
                if (finish_r) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt  = S_START;
                    shadow_nxt = cfg_data;
                    byte_nxt   = 3'd0;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // The register at cfg_index is finished (acked or abandoned): move on,
        // or mark the sweep complete if this was the last index.
        if (close_reg) begin
`ifdef I2C_RETRY_EN
            retry_nxt = '0;
`endif
            if (cfg_index == LAST_IX) begin
                finish_nxt = 1'b1;
            end else begin
                index_nxt = cfg_index + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
module tb_sccb_cfg_sequencer;

    typedef struct packed {
        logic [7:0]  unit;
        logic [7:0]  nb;
        logic [7:0]  cyc;
        logic [47:0] bytes;
    } frame_t;

    logic        clk2;
    logic        reset;
    logic        start_a, start_b;
    logic        sda_a, sda_b;
    logic [15:0] cfg_data_a;
    logic [7:0]  cfg_data_b;
    logic [7:0]  cfg_index_a;
    logic [15:0] cfg_index_b;
    logic        sda_w_a, ctrl_h_a, busy_a, done_a, error_a;
    logic        sda_w_b, ctrl_h_b, busy_b, done_b, error_b;
    logic [7:0]  nack_cnt_a, nack_cnt_b;

    logic [15:0] data_tbl [4];
    assign cfg_data_a = data_tbl[cfg_index_a[1:0]];
    assign cfg_data_b = 8'h7E;

    int n_cmp = 0;
    int n_bad = 0;

    frame_t exp_q[$];

    // Responder (slave model) controls
    logic       nack_en;
    logic [7:0] nack_idx;
    int         nack_byte;
    int         nack_times;
    int         r_att;
    logic       r_in;
    int         r_low;

    // Monitor state per unit
    logic        m_in    [2];
    int          m_cyc   [2];
    int          m_low   [2];
    int          m_nb    [2];
    logic [7:0]  m_sh    [2];
    logic [47:0] m_bytes [2];

    sccb_cfg_sequencer #(
        .START_IDX (0),
        .END_IDX   (2)
    ) u_a (
        .clk2      (clk2),
        .reset     (reset),
        .start     (start_a),
        .sda       (sda_a),
        .cfg_data  (cfg_data_a),
        .cfg_index (cfg_index_a),
        .sda_w     (sda_w_a),
        .ctrl_h    (ctrl_h_a),
        .busy      (busy_a),
        .done      (done_a),
        .error     (error_a),
        .nack_cnt  (nack_cnt_a)
    );

    sccb_cfg_sequencer #(
        .REG_BYTES  (2),
        .DATA_BYTES (1),
        .IDX_W      (16),
        .START_IDX  (16'h0123),
        .END_IDX    (16'h0123)
    ) u_b (
        .clk2      (clk2),
        .reset     (reset),
        .start     (start_b),
        .sda       (sda_b),
        .cfg_data  (cfg_data_b),
        .cfg_index (cfg_index_b),
        .sda_w     (sda_w_b),
        .ctrl_h    (ctrl_h_b),
        .busy      (busy_b),
        .done      (done_b),
        .error     (error_b),
        .nack_cnt  (nack_cnt_b)
    );

    initial begin
        clk2 = 1'b0;
        forever #5 clk2 = ~clk2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic u, input int nb, input logic [47:0] by, input int cyc);
        frame_t f;
        f.unit  = {7'd0, u};
        f.nb    = 8'(nb);
        f.cyc   = 8'(cyc);
        f.bytes = by;
        exp_q.push_back(f);
    endtask

    // Decode one bus cycle of a unit; a frame starts on SCL-high/SDA-low
    // while idle and ends at STOP1, the first SCL-high cycle after the bits.
    task automatic mon_step(input logic u, input logic ch, input logic sw);
        frame_t got, e;
        if (!m_in[u]) begin
            if (ch && !sw) begin
                m_in[u]    = 1'b1;
                m_cyc[u]   = 1;
                m_low[u]   = 0;
                m_nb[u]    = 0;
                m_sh[u]    = 8'd0;
                m_bytes[u] = 48'd0;
            end
        end else begin
            m_cyc[u]++;
            if (!ch) begin
                if (m_low[u] % 9 != 8) begin
                    m_sh[u] = {m_sh[u][6:0], sw};
                end else begin
                    m_bytes[u] = {m_bytes[u][39:0], m_sh[u]};
                    m_nb[u]++;
                end
                m_low[u]++;
            end else begin
                m_in[u]   = 1'b0;
                got.unit  = {7'd0, u};
                got.nb    = 8'(m_nb[u]);
                got.cyc   = 8'(m_cyc[u] + 1);
                got.bytes = m_bytes[u];
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL frame_unexpected: got unit=%0d n=%0d cyc=%0d bytes=%h, expected no frame",
                             got.unit, got.nb, got.cyc, got.bytes);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_bad++;
                        $display("FAIL frame: got unit=%0d n=%0d cyc=%0d bytes=%h, expected unit=%0d n=%0d cyc=%0d bytes=%h",
                                 got.unit, got.nb, got.cyc, got.bytes, e.unit, e.nb, e.cyc, e.bytes);
                    end
                end
            end
        end
    endtask

    // Monitor: samples bus outputs on the negedge, away from the update edge.
    initial begin
        m_in[0] = 1'b0;
        m_in[1] = 1'b0;
        forever begin
            @(negedge clk2);
            if (!reset) begin
                m_in[0] = 1'b0;
                m_in[1] = 1'b0;
            end else begin
                mon_step(1'b0, ctrl_h_a, sda_w_a);
                mon_step(1'b1, ctrl_h_b, sda_w_b);
            end
        end
    end

    // Slave model for unit a: ACKs everything unless told to NACK a given byte.
    initial begin
        r_in  = 1'b0;
        r_low = 0;
        sda_a = 1'b0;
        forever begin
            @(posedge clk2);
            #1;
            if (!reset) begin
                r_in  = 1'b0;
                sda_a = 1'b0;
            end else if (!r_in) begin
                sda_a = 1'b0;
                if (ctrl_h_a && !sda_w_a) begin
                    r_in  = 1'b1;
                    r_low = 0;
                    if (cfg_index_a == nack_idx) r_att++;
                end
            end else if (!ctrl_h_a) begin
                if (r_low % 9 == 8 && nack_en && cfg_index_a == nack_idx &&
                    r_low / 9 == nack_byte && r_att <= nack_times)
                    sda_a = 1'b1;
                else
                    sda_a = 1'b0;
                r_low++;
            end else begin
                r_in  = 1'b0;
                sda_a = 1'b0;
            end
        end
    end

    task automatic reset_pulse();
        @(negedge clk2);
        reset = 1'b0;
        @(negedge clk2);
        reset = 1'b1;
        r_att = 0;
    endtask

    task automatic pulse_start(input logic u);
        @(posedge clk2);
        #1;
        if (u) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk2);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input logic u);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk2);
            if ((u ? done_b : done_a) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("sweep_done", 32'(seen), 1);
        chk("frames_pending", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: got no end of test, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        sda_b      = 1'b0;
        nack_en    = 1'b0;
        nack_idx   = 8'd0;
        nack_byte  = 0;
        nack_times = 0;
        r_att      = 0;
        for (int i = 0; i < 4; i++) data_tbl[i] = 16'hA55A;

        // Reset state
        repeat (3) @(posedge clk2);
        @(negedge clk2);
        chk("rst_sda_w",     32'(sda_w_a), 1);
        chk("rst_ctrl_h",    32'(ctrl_h_a), 1);
        chk("rst_busy",      32'(busy_a), 0);
        chk("rst_done",      32'(done_a), 0);
        chk("rst_error",     32'(error_a), 0);
        chk("rst_nack_cnt",  32'(nack_cnt_a), 0);
        chk("rst_cfg_index", 32'(cfg_index_a), 0);
        chk("rst_cfg_index_b", 32'(cfg_index_b), 32'h0123);
        reset = 1'b1;

        // Plain sweep of indices 0..2, all ACKed
        push(1'b0, 4, 48'h0000_BA00_A55A, 39);
        push(1'b0, 4, 48'h0000_BA01_A55A, 39);
        push(1'b0, 4, 48'h0000_BA02_A55A, 39);
        pulse_start(1'b0);
        chk("t1_busy", 32'(busy_a), 1);
        wait_done(1'b0);
        chk("t1_error",     32'(error_a), 0);
        chk("t1_nack_cnt",  32'(nack_cnt_a), 0);
        chk("t1_cfg_index", 32'(cfg_index_a), 2);
        chk("t1_busy_end",  32'(busy_a), 0);

        // Permanent NACK on the register byte of index 1
        reset_pulse();
        data_tbl[0] = 16'h1111;
        data_tbl[1] = 16'h2222;
        data_tbl[2] = 16'h3333;
        nack_en    = 1'b1;
        nack_idx   = 8'd1;
        nack_byte  = 1;
        nack_times = 255;
        push(1'b0, 4, 48'h0000_BA00_1111, 39);
`ifdef I2C_RETRY_EN
        for (int i = 0; i < 4; i++) push(1'b0, 2, 48'h0000_0000_BA01, 21);
`else
        push(1'b0, 2, 48'h0000_0000_BA01, 21);
`endif
        push(1'b0, 4, 48'h0000_BA02_3333, 39);
        pulse_start(1'b0);
        wait_done(1'b0);
        chk("t2_error", 32'(error_a), 1);
`ifdef I2C_RETRY_EN
        chk("t2_nack_cnt", 32'(nack_cnt_a), 4);
`else
        chk("t2_nack_cnt", 32'(nack_cnt_a), 1);
`endif
        chk("t2_cfg_index", 32'(cfg_index_a), 2);

        // Single NACK on the last data byte of index 0's first attempt
        reset_pulse();
        nack_idx   = 8'd0;
        nack_byte  = 3;
        nack_times = 1;
        push(1'b0, 4, 48'h0000_BA00_1111, 39);
`ifdef I2C_RETRY_EN
        push(1'b0, 4, 48'h0000_BA00_1111, 39);
`endif
        push(1'b0, 4, 48'h0000_BA01_2222, 39);
        push(1'b0, 4, 48'h0000_BA02_3333, 39);
        pulse_start(1'b0);
        wait_done(1'b0);
`ifdef I2C_RETRY_EN
        chk("t3_error", 32'(error_a), 0);
`else
        chk("t3_error", 32'(error_a), 1);
`endif
        chk("t3_nack_cnt", 32'(nack_cnt_a), 1);

        // Reset during the first data byte of index 1, then a fresh sweep
        reset_pulse();
        nack_en = 1'b0;
        push(1'b0, 4, 48'h0000_BA00_1111, 39);
        @(posedge clk2);
        #1;
        start_a = 1'b1;
        @(posedge clk2);
        #1;
        start_a = 1'b0;
        repeat (60) @(posedge clk2);
        #2;
        chk("t4_pre_ctrl_h",    32'(ctrl_h_a), 0);
        chk("t4_pre_cfg_index", 32'(cfg_index_a), 1);
        reset = 1'b0;
        @(negedge clk2);
        chk("t4_sda_w",     32'(sda_w_a), 1);
        chk("t4_ctrl_h",    32'(ctrl_h_a), 1);
        chk("t4_busy",      32'(busy_a), 0);
        chk("t4_cfg_index", 32'(cfg_index_a), 0);
        @(negedge clk2);
        reset = 1'b1;
        r_att = 0;
        push(1'b0, 4, 48'h0000_BA00_1111, 39);
        push(1'b0, 4, 48'h0000_BA01_2222, 39);
        push(1'b0, 4, 48'h0000_BA02_3333, 39);
        pulse_start(1'b0);
        wait_done(1'b0);
        chk("t4_error", 32'(error_a), 0);

        // Two-byte register address, one data byte
        push(1'b1, 4, 48'h0000_BA01_237E, 39);
        pulse_start(1'b1);
        wait_done(1'b1);
        chk("t5_cfg_index", 32'(cfg_index_b), 32'h0123);
        chk("t5_error",     32'(error_b), 0);
        chk("t5_nack_cnt",  32'(nack_cnt_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
